// File: rtl/alu_cmp_pkg.sv
// Shared encodings for the ALU compare issuer: relation codes, comparator
// opcodes, FSM states and the relation-to-opcode mapping.
package alu_cmp_pkg;

    localparam logic [1:0] REL_EQ = 2'b00;
    localparam logic [1:0] REL_NE = 2'b01;
    localparam logic [1:0] REL_GT = 2'b10;
    localparam logic [1:0] REL_LT = 2'b11;

    localparam logic [3:0] OP_EQ   = 4'b1001;
    localparam logic [3:0] OP_NE   = 4'b1011;
    localparam logic [3:0] OP_GT   = 4'b1101;
    localparam logic [3:0] OP_LT   = 4'b1111;
    localparam logic [3:0] OP_IDLE = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic logic [3:0] rel_to_op(input logic [1:0] rel);
        logic [3:0] op;
        case (rel)
            REL_EQ:  op = OP_EQ;
            REL_NE:  op = OP_NE;
            REL_GT:  op = OP_GT;
            REL_LT:  op = OP_LT;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cmp_operand_gen.sv
// Combinational operand preparation for the comparator: difference,
// signed-overflow flag of the difference, and bitwise XOR.
module cmp_operand_gen #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sub_o,
    output logic         of_o,
    output logic [W-1:0] xor_o
);

    // Overflow only when operand signs differ and the result sign departs from A.
    always_comb begin
        sub_o = a_i - b_i;
        of_o  = (a_i[W-1] != b_i[W-1]) && (sub_o[W-1] != a_i[W-1]);
        xor_o = a_i ^ b_i;
    end

endmodule

// File: rtl/alu_cmp_issuer.sv
// Issues one signed comparison to an external comparator, waits for it to
// settle, and holds the one-bit answer until the consumer takes it.
module alu_cmp_issuer
    import alu_cmp_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic [1:0]   req_rel,
    output logic [W-1:0] cmp_sub,
    output logic         cmp_of,
    output logic [W-1:0] cmp_xor,
    output logic [3:0]   cmp_op,
    input  logic [3:0]   cmp_outp,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_result,
    output logic         rsp_err,
    output logic [7:0]   done_cnt
);

    state_e       state_q;
    logic         req_ready_q;
    logic [W-1:0] cmp_sub_q;
    logic         cmp_of_q;
    logic [W-1:0] cmp_xor_q;
    logic [3:0]   cmp_op_q;
    logic         rsp_valid_q;
    logic         rsp_result_q;
    logic         rsp_err_q;
    logic [7:0]   done_cnt_q;

    logic [W-1:0] sub_s;
    logic         of_s;
    logic [W-1:0] xor_s;

    cmp_operand_gen #(.W(W)) u_operand_gen (
        .a_i   (req_a),
        .b_i   (req_b),
        .sub_o (sub_s),
        .of_o  (of_s),
        .xor_o (xor_s)
    );

    // Transaction FSM: capture, drive comparator for two cycles, hold response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            cmp_sub_q    <= '0;
            cmp_of_q     <= 1'b0;
            cmp_xor_q    <= '0;
            cmp_op_q     <= OP_IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 1'b0;
            rsp_err_q    <= 1'b0;
            done_cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        cmp_sub_q   <= sub_s;
                        cmp_of_q    <= of_s;
                        cmp_xor_q   <= xor_s;
                        cmp_op_q    <= rel_to_op(req_rel);
                        req_ready_q <= 1'b0;
                        state_q     <= ST_ISSUE;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    rsp_result_q <= cmp_outp[0];
                    rsp_err_q    <= |cmp_outp[3:1];
                    rsp_valid_q  <= 1'b1;
                    cmp_op_q     <= OP_IDLE;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                        if (done_cnt_q != 8'hFF) begin
                            done_cnt_q <= done_cnt_q + 8'd1;
                        end else begin
                            done_cnt_q <= done_cnt_q;
                        end
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    cmp_op_q    <= OP_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign cmp_sub    = cmp_sub_q;
    assign cmp_of     = cmp_of_q;
    assign cmp_xor    = cmp_xor_q;
    assign cmp_op     = cmp_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_alu_cmp_issuer.sv
// Self-checking bench for alu_cmp_issuer: comparator responder, transaction-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_alu_cmp_issuer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_a = 4'd0;
    logic [3:0] req_b = 4'd0;
    logic [1:0] req_rel = 2'd0;
    logic [3:0] cmp_sub;
    logic       cmp_of;
    logic [3:0] cmp_xor;
    logic [3:0] cmp_op;
    logic [3:0] cmp_outp;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_result;
    logic       rsp_err;
    logic [7:0] done_cnt;
    logic       stub_mode = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_cmp_issuer #(.W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_rel    (req_rel),
        .cmp_sub    (cmp_sub),
        .cmp_of     (cmp_of),
        .cmp_xor    (cmp_xor),
        .cmp_op     (cmp_op),
        .cmp_outp   (cmp_outp),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .done_cnt   (done_cnt)
    );

    // Comparator responder: decides the relation from sub/of/xor and opcode.
    always_comb begin
        logic lt;
        logic eq;
        logic res;
        lt  = cmp_of ^ cmp_sub[3];
        eq  = (cmp_xor == 4'd0);
        case (cmp_op)
            4'b1001: res = eq;
            4'b1011: res = !eq;
            4'b1101: res = !lt && !eq;
            4'b1111: res = lt;
            default: res = 1'b0;
        endcase
        cmp_outp = stub_mode ? 4'b1001 : {3'b000, res};
    end

    function automatic void chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endfunction

    function automatic int sval(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    function automatic logic holds(input logic [3:0] a, input logic [3:0] b, input logic [1:0] rel);
        case (rel)
            2'd0:    return sval(a) == sval(b);
            2'd1:    return sval(a) != sval(b);
            2'd2:    return sval(a) >  sval(b);
            default: return sval(a) <  sval(b);
        endcase
    endfunction

    function automatic logic [3:0] opcode(input logic [1:0] rel);
        case (rel)
            2'd0:    return 4'b1001;
            2'd1:    return 4'b1011;
            2'd2:    return 4'b1101;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [3:0] diff4(input logic [3:0] a, input logic [3:0] b);
        int d;
        d = (int'(a) - int'(b)) & 15;
        return d[3:0];
    endfunction

    function automatic logic ovf(input logic [3:0] a, input logic [3:0] b);
        int d;
        d = sval(a) - sval(b);
        return (d > 7) || (d < -8);
    endfunction

    // Reference model: m_age counts edges since acceptance, 3 = response held.
    logic       m_busy;
    int         m_age;
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [1:0] m_rel;
    logic       m_res;
    logic       m_err;
    int         m_done;

    // Model update on each clock edge, cleared asynchronously by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_age  <= 0;
            m_a    <= 4'd0;
            m_b    <= 4'd0;
            m_rel  <= 2'd0;
            m_res  <= 1'b0;
            m_err  <= 1'b0;
            m_done <= 0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_a    <= req_a;
                m_b    <= req_b;
                m_rel  <= req_rel;
            end
        end else if (m_age < 3) begin
            m_age <= m_age + 1;
            if (m_age == 2) begin
                m_res <= stub_mode ? 1'b1 : holds(m_a, m_b, m_rel);
                m_err <= stub_mode;
            end
        end else if (rsp_ready) begin
            m_busy <= 1'b0;
            m_done <= (m_done < 255) ? m_done + 1 : 255;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        chk("req_ready", req_ready, !m_busy);
        chk("rsp_valid", rsp_valid, m_busy && (m_age == 3));
        chk("cmp_op", cmp_op, (m_busy && m_age < 3) ? opcode(m_rel) : 4'b0000);
        chk("cmp_sub", cmp_sub, diff4(m_a, m_b));
        chk("cmp_xor", cmp_xor, m_a ^ m_b);
        chk("cmp_of", cmp_of, ovf(m_a, m_b));
        chk("done_cnt", done_cnt, m_done[7:0]);
        if ((m_busy && m_age == 3) || !rst_n) begin
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_err", rsp_err, m_err);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits for an idle slot, presents the request for one edge; returns in ISSUE.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] rel);
        int n;
        n = 0;
        while (m_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", (n < 20), 1'b1);
        req_a = a;
        req_b = b;
        req_rel = rel;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", (n < 20), 1'b1);
    endtask

    initial begin
        do_reset();

        // A=5, B=3, GT
        send(4'd5, 4'd3, 2'b10);
        chk("t1_sub", cmp_sub, 8'h02);
        chk("t1_of", cmp_of, 1'b0);
        chk("t1_xor", cmp_xor, 8'h06);
        chk("t1_op", cmp_op, 8'h0D);
        @(negedge clk);
        chk("t1_valid_early", rsp_valid, 1'b0);
        @(negedge clk);
        chk("t1_valid", rsp_valid, 1'b1);
        chk("t1_result", rsp_result, 1'b1);

        // A=7, B=-8: overflowing difference, LT then GT
        send(4'd7, 4'b1000, 2'b11);
        chk("t2_sub", cmp_sub, 8'h0F);
        chk("t2_of", cmp_of, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t2_lt_result", rsp_result, 1'b0);
        send(4'd7, 4'b1000, 2'b10);
        @(negedge clk);
        @(negedge clk);
        chk("t2_gt_result", rsp_result, 1'b1);

        // A=-8, B=1 LT: other overflow direction
        send(4'b1000, 4'd1, 2'b11);
        chk("t2b_of", cmp_of, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t2b_result", rsp_result, 1'b1);

        // A=B=4, EQ then NE, fresh counter
        do_reset();
        send(4'd4, 4'd4, 2'b00);
        chk("t3_xor", cmp_xor, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("t3_eq_result", rsp_result, 1'b1);
        send(4'd4, 4'd4, 2'b01);
        @(negedge clk);
        @(negedge clk);
        chk("t3_ne_result", rsp_result, 1'b0);
        wait_idle();
        chk("t3_done", done_cnt, 8'd2);

        // Consumer stall: 2 > -3 held for 5 cycles with a competing request pending
        rsp_ready = 1'b0;
        send(4'd2, 4'b1101, 2'b10);
        req_a = 4'd1;
        req_b = 4'd1;
        req_rel = 2'b00;
        req_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", rsp_valid, 1'b1);
            chk("t4_hold_result", rsp_result, 1'b1);
            chk("t4_hold_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_back_idle", req_ready, 1'b1);
        chk("t4_rsp_clear", rsp_valid, 1'b0);
        chk("t4_done", done_cnt, 8'd3);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t4_next_op", cmp_op, 8'h09);
        @(negedge clk);
        @(negedge clk);
        chk("t4_next_result", rsp_result, 1'b1);

        // Reset during SETTLE discards the transaction
        do_reset();
        send(4'd3, 4'd1, 2'b10);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", rsp_valid, 1'b0);
        chk("t5_rst_ready", req_ready, 1'b1);
        chk("t5_rst_op", cmp_op, 8'h00);
        chk("t5_rst_sub", cmp_sub, 8'h00);
        chk("t5_rst_xor", cmp_xor, 8'h00);
        chk("t5_rst_done", done_cnt, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_rsp", rsp_valid, 1'b0);

        // Stub comparator drives 1001: error flag with result 1
        stub_mode = 1'b1;
        send(4'd1, 4'd2, 2'b10);
        @(negedge clk);
        @(negedge clk);
        chk("t6_err", rsp_err, 1'b1);
        chk("t6_result", rsp_result, 1'b1);
        wait_idle();
        stub_mode = 1'b0;

        // All 256 operand pairs; counter must saturate at 255
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = i[7:0];
            send(v[3:0], v[7:4], v[1:0] ^ v[5:4]);
        end
        wait_idle();
        chk("t7_saturate", done_cnt, 8'd255);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmp_issuer.md
ALU_CMP_ISSUER -- requirements
Module: alu_cmp_issuer

Interface
REQ-001: Parameter W, default 4, operand width; only W=4 is supported, matching the 4-bit ALU datapath.
REQ-002: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003: rst_n  input  1  reset; asynchronous and active-low.
REQ-004: req_valid  input  1  the request carries a valid comparison.
REQ-005: req_ready  output  1  the block can accept a request.
REQ-006: req_a, req_b  input  4 each  signed two's-complement operands A and B.
REQ-007: req_rel  input  2  relation: 00 EQ, 01 NE, 10 GT, 11 LT.
REQ-008: cmp_sub  output  4  registered A-B (mod 16) to the comparator.
REQ-009: cmp_of  output  1  registered signed-overflow flag of A-B.
REQ-010: cmp_xor  output  4  registered A^B.
REQ-011: cmp_op  output  4  registered opcode: EQ 1001, NE 1011, GT 1101, LT 1111; idle value 0000.
REQ-012: cmp_outp  input  4  comparator result; bit 0 is the answer, bits 3:1 are expected to be zero.
REQ-013: rsp_valid  output  1  a response is held.
REQ-014: rsp_ready  input  1  the consumer takes the response.
REQ-015: rsp_result  output  1  the relation holds.
REQ-016: rsp_err  output  1  cmp_outp[3:1] was non-zero when sampled.
REQ-017: done_cnt  output  8  count of completed responses.

Function
REQ-018: The FSM shall have exactly four states: IDLE, ISSUE, SETTLE and RESP.
REQ-019: req_ready shall equal 1 only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-020: On acceptance the block shall register sub=A-B[3:0], of=(A[3]!=B[3])&&(sub[3]!=A[3]), xor=A^B and the opcode mapped from req_rel, then enter ISSUE.
REQ-021: ISSUE shall last one cycle and then go to SETTLE; cmp_* shall hold the captured values throughout ISSUE and SETTLE.
REQ-022: At the edge that leaves SETTLE, the block shall sample rsp_result=cmp_outp[0] and rsp_err=|cmp_outp[3:1], then enter RESP.
REQ-023: Latency: a request accepted at edge N shall give rsp_valid=1 after edge N+2.
REQ-024: In RESP, rsp_valid shall be 1 and rsp_result/rsp_err shall stay stable until the edge where rsp_ready=1, after which the block returns to IDLE.
REQ-025: Back-to-back throughput shall be at most one transaction per 4 cycles; no request is accepted while in RESP, even when rsp_ready=1.
REQ-026: Outside ISSUE and SETTLE, cmp_op shall be 0000; cmp_sub, cmp_xor and cmp_of keep their last value.
REQ-027: done_cnt shall increment at each RESP->IDLE handshake and saturate at 255 without wrapping.
REQ-028: Overflow cases (e.g. A=7,B=-8; A=-8,B=1) shall set cmp_of=1 so the comparator's of^sub[3] rule still yields the correct signed order.

Reset
REQ-029: While rst_n=0, the block shall enter IDLE asynchronously with req_ready=1, rsp_valid=0, rsp_result=0, rsp_err=0, cmp_sub=0, cmp_of=0, cmp_xor=0, cmp_op=0000 and done_cnt=0.
REQ-030: Reset asserted in any state, including mid-transaction, shall discard the transaction without producing a response.
REQ-031: After rst_n deasserts, the first request shall be acceptable at the first rising edge.

Structure
REQ-032: The shared package alu_cmp_pkg shall hold the rel encoding, the opcode constants OP_EQ/OP_NE/OP_GT/OP_LT/OP_IDLE and the state enumeration.
REQ-033: A combinational sub-module, cmp_operand_gen, shall compute sub, of and xor from A and B; alu_cmp_issuer owns all registers and the FSM.

Verification (bench instantiates the Comparatorf-equivalent responder on cmp_*)
REQ-034: A=5,B=3,GT, rsp_ready=1 -> cmp_sub=0010, cmp_of=0, cmp_xor=0110, cmp_op=1101; rsp_result=1 two edges after acceptance.
REQ-035: A=7,B=-8(1000),LT -> cmp_sub=1111, cmp_of=1, rsp_result=0; then the same operands with GT -> rsp_result=1.
REQ-036: A=4,B=4 with EQ then NE -> cmp_xor=0000; rsp_result=1 then 0; done_cnt=2.
REQ-037: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_result stable and req_ready=0 throughout; a single handshake then returns the block to IDLE.
REQ-038: rst_n pulsed low during SETTLE -> all outputs at reset values immediately, no response, done_cnt=0; a stub driving cmp_outp=1001 -> rsp_err=1, rsp_result=1.
